// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_pkg
// Description : Shared constants for the UART transmitter. Holds the 2-bit
//               serialiser state encodings, the 8N1 frame geometry and a
//               helper that derives the per-bit clock count.
// Revision    : 1.0  initial release
// ============================================================================
package uart_tx_fifo_pkg;

    // Serialiser state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // 8N1 frame: one start bit, eight data bits, one stop bit
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    // Clock cycles per serial bit (integer division, truncated)
    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage : uart_tx_fifo_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. rd_data always
//               shows the head entry; rd_en pops it. Writes while full and
//               reads while empty are ignored.
// Ports       : clk     - clock, rising edge
//               reset   - asynchronous active-low reset
//               wr_en   - write strobe
//               wr_data - data to enqueue
//               rd_en   - pop strobe
//               rd_data - head entry (valid when empty=0)
//               full    - count == DEPTH
//               empty   - count == 0
//               count   - number of stored entries
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic w_wr_accept;
    logic w_rd_accept;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Accept decisions use the pre-edge flags, so a write into a full FIFO
    // is dropped even if a pop happens in the same cycle.
    assign w_wr_accept = wr_en & ~full;
    assign w_rd_accept = rd_en & ~empty;

    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (w_wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_rd_accept) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_wr_accept, w_rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte-oriented 8N1 UART transmitter (LSB first) fed by an
//               input FIFO, with full/empty backpressure and a sticky
//               overflow flag.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-low reset
//               uart_write - write strobe (accepted when uart_full=0)
//               uart_data  - byte to enqueue
//               uart_full  - FIFO holds FIFO_DEPTH bytes
//               uart_empty - FIFO holds no bytes
//               busy       - serialiser is sending a frame
//               overflow   - sticky, a write arrived while full
//               tx         - serial line, idle high
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_write,
    input  logic [7:0] uart_data,
    output logic       uart_full,
    output logic       uart_empty,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    import uart_tx_fifo_pkg::*;

    // CLKS_PER_BIT must be >= 2 for the baud counter to be meaningful.
    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);

    // FIFO interface
    logic [7:0]       w_rd_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_pop;
    logic             w_bit_end;

    // Serialiser state
    logic [1:0]        state_q,    state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q,  bit_idx_d;
    logic [7:0]        shift_q,    shift_d;
    logic              tx_q,       tx_d;
    logic              overflow_q, overflow_d;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (uart_write),
        .wr_data (uart_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    assign uart_full  = w_fifo_full;
    assign uart_empty = (w_fifo_count == '0);
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = overflow_q;
    assign tx         = tx_q;

    assign w_bit_end  = (baud_cnt_q == BAUD_LAST);

    // tx is registered: each state loads the level of the *next* bit on the
    // edge that ends the current one, so the line never glitches.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        w_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    shift_d    = w_rd_data;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = 1'b0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (w_bit_end) begin
                    baud_cnt_d = '0;
                    tx_d       = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == DATA_LAST) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_d];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            ST_STOP: begin
                if (w_bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky: set on any write attempt while full, cleared only by reset.
    always_comb begin
        overflow_d = overflow_q | (uart_write & w_fifo_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=10
//               and a 4-entry FIFO. Accepted bytes go into a scoreboard
//               queue and are compared against bytes decoded from tx.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 10;

    logic       clk;
    logic       reset;
    logic       uart_write;
    logic [7:0] uart_data;
    logic       uart_full;
    logic       uart_empty;
    logic       busy;
    logic       overflow;
    logic       tx;

    int errors = 0;
    int checks = 0;
    int full_cycles = 0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_write (uart_write),
        .uart_data  (uart_data),
        .uart_full  (uart_full),
        .uart_empty (uart_empty),
        .busy       (busy),
        .overflow   (overflow),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uart_full === 1'b1) full_cycles++;
    end

    // One-cycle write pulse, launched and finished on falling edges.
    task automatic wr(input logic [7:0] d);
        uart_write = 1'b1;
        uart_data  = d;
        @(negedge clk);
        uart_write = 1'b0;
    endtask

    // Decode one frame. If tx is already low, that cycle is taken as the
    // start; gap returns the number of falling edges waited for the start.
    task automatic rx_byte(output logic [7:0] b, output int gap);
        int n = 0;
        b = '0;
        while (tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        gap = n;
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rx_start_timeout: tx=%b after %0d cycles, required 0", tx, n);
            return;
        end
        repeat (CPB/2 - 1) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rx_start_mid: tx=%b, required 0", tx);
        end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rx_stop: tx=%b, required 1", tx);
        end
    endtask

    task automatic check_next(input string name, input logic [7:0] got);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got byte %02h, scoreboard empty", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got byte %02h, required %02h", name, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        uart_write = 1'b0;
        uart_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, uart_empty, uart_full, busy, overflow} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: tx,empty,full,busy,ovf=%b required 11000",
                         i, {tx, uart_empty, uart_full, busy, overflow});
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic       exp_tx;
        d = 8'hA5;
        wr(d);
        checks++;
        if ({tx, busy, uart_empty} !== 3'b100) begin
            errors++;
            $display("FAIL single_accept: tx,busy,empty=%b required 100", {tx, busy, uart_empty});
        end
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            if (i < CPB)                exp_tx = 1'b0;
            else if (i >= 9 * CPB)      exp_tx = 1'b1;
            else                        exp_tx = d[i / CPB - 1];
            checks++;
            if ({tx, busy} !== {exp_tx, 1'b1}) begin
                errors++;
                $display("FAIL single_frame cyc %0d: tx,busy=%b required %b",
                         i, {tx, busy}, {exp_tx, 1'b1});
            end
        end
        @(negedge clk);
        checks++;
        if ({tx, busy, uart_empty} !== 3'b101) begin
            errors++;
            $display("FAIL single_end: tx,busy,empty=%b required 101", {tx, busy, uart_empty});
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        int gap;
        wr(8'h01); exp_q.push_back(8'h01);
        wr(8'h02); exp_q.push_back(8'h02);
        rx_byte(got, gap);
        check_next("b2b_byte0", got);
        rx_byte(got, gap);
        check_next("b2b_byte1", got);
        // Sampling mid-stop at offset 94; next start expected at 101.
        checks++;
        if (gap !== 7) begin
            errors++;
            $display("FAIL b2b_gap: waited %0d cycles, required 7", gap);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] got;
        int gap;
        logic exp_full [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int highs = 0;
        for (int k = 0; k < 6; k++) begin
            wr(8'h10 + 8'(k));
            if (k < 5) exp_q.push_back(8'h10 + 8'(k));
            checks++;
            if ({uart_full, overflow} !== {exp_full[k], exp_ovf[k]}) begin
                errors++;
                $display("FAIL ovf_write%0d: full,ovf=%b required %b",
                         k, {uart_full, overflow}, {exp_full[k], exp_ovf[k]});
            end
        end
        for (int k = 0; k < 5; k++) begin
            rx_byte(got, gap);
            check_next($sformatf("ovf_byte%0d", k), got);
            if (k >= 2) begin
                checks++;
                if (gap !== 7) begin
                    errors++;
                    $display("FAIL ovf_gap%0d: waited %0d cycles, required 7", k, gap);
                end
            end
        end
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx === 1'b1) highs++;
        end
        checks++;
        if (highs !== 150 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: idle-high cycles=%0d ovf=%b, required 150 and 1", highs, overflow);
        end
    endtask

    task automatic test_controller();
        logic [7:0] got0, got1;
        int gap0, gap1;
        int full_start;
        full_start = full_cycles;
        wr(8'h70); exp_q.push_back(8'h70);
        fork
            begin
                repeat (30) @(negedge clk);
                wr(8'h03);
            end
            begin
                rx_byte(got0, gap0);
                rx_byte(got1, gap1);
            end
        join
        exp_q.push_back(8'h03);
        check_next("ctrl_byte0", got0);
        check_next("ctrl_byte1", got1);
        checks++;
        if (gap1 !== 7) begin
            errors++;
            $display("FAIL ctrl_gap: waited %0d cycles, required 7", gap1);
        end
        checks++;
        if (full_cycles !== full_start) begin
            errors++;
            $display("FAIL ctrl_never_full: full seen %0d cycles, required 0", full_cycles - full_start);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        wr(8'hFF);
        wr(8'h11);
        wr(8'h22);
        // Frame started at the edge after the first write; now at offset 1.
        repeat (44) @(negedge clk);
        checks++;
        if ({tx, busy, uart_empty, overflow} !== 4'b1101) begin
            errors++;
            $display("FAIL mid_before: tx,busy,empty,ovf=%b required 1101",
                     {tx, busy, uart_empty, overflow});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({tx, uart_empty, uart_full, busy, overflow} !== 5'b11000) begin
            errors++;
            $display("FAIL mid_reset: tx,empty,full,busy,ovf=%b required 11000",
                     {tx, uart_empty, uart_full, busy, overflow});
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if ({tx, busy, uart_empty} !== 3'b101) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_after_release: %0d cycles not idle, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_controller();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_fifo
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-oriented UART transmitter with an input FIFO.
- Sits directly downstream of the test controller and consumes its `uart_write`/`uart_data` byte stream (result byte, then page number).
- Serialises bytes 8N1, LSB first, onto the board TX pin.
- Provides the `uart_full` backpressure flag the controller polls before each write.

Parameters:
- CLOCK_FREQ, 25000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer, truncated), must be >= 2.
- FIFO_DEPTH, 16: FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- uart_write  input  1  write strobe; one byte accepted per cycle when high and uart_full=0.
- uart_data  input  8  byte to enqueue; sampled with uart_write.
- uart_full  output  1  FIFO holds FIFO_DEPTH bytes.
- uart_empty  output  1  FIFO holds 0 bytes.
- busy  output  1  serialiser not in IDLE.
- overflow  output  1  sticky; set when uart_write=1 while uart_full=1.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, sync release): FIFO count=0, rd_ptr=wr_ptr=0, state=IDLE, tx=1, busy=0, overflow=0, uart_full=0, uart_empty=1. Reset mid-frame aborts the frame immediately (tx=1) and discards queued bytes.
- FIFO:
  - count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - uart_full = (count==FIFO_DEPTH) and uart_empty = (count==0), both combinational from registered count.
  - Write accepted iff uart_write=1 and uart_full=0; else byte is dropped and overflow<=1.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - Full + write + pop in same cycle: write is still dropped (decision uses pre-edge uart_full).
- Serialiser states IDLE, START, DATA, STOP, each bit lasting exactly CLKS_PER_BIT cycles via baud_cnt (0..CLKS_PER_BIT-1):
  - IDLE: tx=1. If uart_empty=0, pop head into shift_reg, baud_cnt<=0, bit_idx<=0, tx<=0, go START.
  - START: tx=0; at baud_cnt=CLKS_PER_BIT-1, tx<=shift_reg[0], go DATA.
  - DATA: tx=shift_reg[bit_idx]; at end of bit, if bit_idx=7 then tx<=1, go STOP, else bit_idx+1.
  - STOP: tx=1; at end of bit, go IDLE.
- Latency and framing:
  - Write into empty FIFO accepted at edge E0; FSM pops at E1; tx low from E1.
  - Frame = 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly 1 idle-high cycle between stop bit end and next start bit.
  - busy=1 from START through last STOP cycle.
- overflow clears only on reset.

Decomposition:
- Shared constants header (uart_defs): serialiser state encodings (2-bit), frame bit count (10).
- One sub-module, sync_fifo (DEPTH, WIDTH params; wr_en/wr_data/rd_en/rd_data/full/empty/count, same clk/reset).
- uart_tx_fifo instantiates sync_fifo and holds the FSM, baud counter, shift register and overflow flag.

Test Plan (CLOCK_FREQ=1000, BAUD_RATE=100 → CLKS_PER_BIT=10, FIFO_DEPTH=4):
- Reset released, no writes -> tx=1, uart_empty=1, uart_full=0, busy=0, overflow=0 for 100 cycles.
- Write 0xA5 once -> tx low one cycle after write, for 10 cycles. Then bits 1,0,1,0,0,1,0,1 at 10 cycles each, stop high 10 cycles. busy high 100 cycles.
- Write 0x01,0x02 on consecutive cycles -> two frames, 1 idle-high cycle between them; decoded bytes 0x01 then 0x02.
- Write 6 bytes 0x10..0x15 on consecutive cycles -> first pops at cycle 1. uart_full=1 after 5th write; 6th (0x15) dropped, overflow=1 and stays 1. Line carries 0x10..0x14 only.
- Controller-style traffic: write 0x70, wait 30 cycles, write 0x03 -> two frames 0x70, 0x03; uart_full never asserts.
- Assert reset at cycle 45 of a 0xFF frame with 2 bytes queued -> tx=1 immediately, uart_empty=1, busy=0. No further frames after release.
